// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: word/register aliases, the control word and its NOP encoding.
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose rd feeds the instruction in ID.
module load_use_detect
    import rv32i_types::*;
(
    input  logic       exe_valid_i,
    input  logic       exe_is_load_i,
    input  logic [4:0] exe_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1_i & (id_rs1_i == exe_rd_i);
    assign rs2_hit = id_uses_rs2_i & (id_rs2_i == exe_rd_i);

    // x0 is never written, so a load targeting it cannot create a hazard.
    assign load_use_o = exe_valid_i & exe_is_load_i & (exe_rd_i != 5'd0) &
                        id_valid_i & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and global freeze.
// Optional hazard performance counters are enabled with `define HAZARD_PERF_EN.
module id_ex_stage
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_load_regfile,
    input  logic        id_is_load,
    input  ctrl_word_t  id_ctrl,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        exe_valid,
    output logic [4:0]  exe_rs1,
    output logic [4:0]  exe_rs2,
    output logic [4:0]  exe_rd,
    output logic        exe_load_regfile,
    output logic        exe_is_load,
    output ctrl_word_t  exe_ctrl,
    output logic [31:0] exe_pc,
    output logic [31:0] exe_imm,
    output logic [31:0] exe_rs1_data,
    output logic [31:0] exe_rs2_data,
    output logic        stall_if_id,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count
);

    logic       valid_q, valid_d;
    logic [4:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic       load_regfile_q, load_regfile_d;
    logic       is_load_q, is_load_d;
    ctrl_word_t ctrl_q, ctrl_d;
    rv32i_word  pc_q, pc_d, imm_q, imm_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic       load_use;

    load_use_detect u_load_use_detect (
        .exe_valid_i   (valid_q),
        .exe_is_load_i (is_load_q),
        .exe_rd_i      (rd_q),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .load_use_o    (load_use)
    );

    // A flush already kills the consumer, so IF/ID need not be held.
    assign stall_if_id = load_use & ~flush;

    always_comb begin
        valid_d        = valid_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        rd_d           = rd_q;
        load_regfile_d = load_regfile_q;
        is_load_d      = is_load_q;
        ctrl_d         = ctrl_q;
        pc_d           = pc_q;
        imm_d          = imm_q;
        rs1_data_d     = rs1_data_q;
        rs2_data_d     = rs2_data_q;
        if (!mem_stall) begin
            if (flush || load_use) begin
                valid_d        = 1'b0;
                rs1_d          = '0;
                rs2_d          = '0;
                rd_d           = '0;
                load_regfile_d = 1'b0;
                is_load_d      = 1'b0;
                ctrl_d         = CTRL_NOP;
                pc_d           = '0;
                imm_d          = '0;
                rs1_data_d     = '0;
                rs2_data_d     = '0;
            end else begin
                valid_d        = id_valid;
                rs1_d          = id_rs1;
                rs2_d          = id_rs2;
                rd_d           = id_rd;
                load_regfile_d = id_load_regfile & id_valid;
                is_load_d      = id_is_load & id_valid;
                ctrl_d         = id_ctrl;
                pc_d           = id_pc;
                imm_d          = id_imm;
                rs1_data_d     = id_rs1_data;
                rs2_data_d     = id_rs2_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= 1'b0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= '0;
            load_regfile_q <= 1'b0;
            is_load_q      <= 1'b0;
            ctrl_q         <= CTRL_NOP;
            pc_q           <= '0;
            imm_q          <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
        end else begin
            valid_q        <= valid_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            load_regfile_q <= load_regfile_d;
            is_load_q      <= is_load_d;
            ctrl_q         <= ctrl_d;
            pc_q           <= pc_d;
            imm_q          <= imm_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
        end
    end

    assign exe_valid        = valid_q;
    assign exe_rs1          = rs1_q;
    assign exe_rs2          = rs2_q;
    assign exe_rd           = rd_q;
    assign exe_load_regfile = load_regfile_q;
    assign exe_is_load      = is_load_q;
    assign exe_ctrl         = ctrl_q;
    assign exe_pc           = pc_q;
    assign exe_imm          = imm_q;
    assign exe_rs1_data     = rs1_data_q;
    assign exe_rs2_data     = rs2_data_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    // A simultaneous flush and load-use is one bubble, attributed to the flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (!mem_stall) begin
            if (flush) begin
                if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
            end else if (load_use) begin
                if (bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_count = bubble_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign bubble_count = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios plus randomized traffic vs a reference model.
module tb_id_ex_stage;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2, id_load_regfile, id_is_load;
    ctrl_word_t  id_ctrl;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic        mem_stall, flush;
    logic        exe_valid;
    logic [4:0]  exe_rs1, exe_rs2, exe_rd;
    logic        exe_load_regfile, exe_is_load;
    ctrl_word_t  exe_ctrl;
    logic [31:0] exe_pc, exe_imm, exe_rs1_data, exe_rs2_data;
    logic        stall_if_id;
    logic [31:0] bubble_count, flush_count;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_load_regfile(id_load_regfile), .id_is_load(id_is_load), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_imm(id_imm), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .mem_stall(mem_stall), .flush(flush),
        .exe_valid(exe_valid), .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_rd(exe_rd),
        .exe_load_regfile(exe_load_regfile), .exe_is_load(exe_is_load), .exe_ctrl(exe_ctrl),
        .exe_pc(exe_pc), .exe_imm(exe_imm), .exe_rs1_data(exe_rs1_data), .exe_rs2_data(exe_rs2_data),
        .stall_if_id(stall_if_id), .bubble_count(bubble_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // What the EX stage should hold, tracked as a plain record of the instruction.
    typedef struct packed {
        bit         v;
        bit [4:0]   rs1, rs2, rd;
        bit         lr, il;
        ctrl_word_t ctrl;
        bit [31:0]  pc, imm, d1, d2;
    } ex_t;

    ex_t       m;
    bit [31:0] m_bub = 0, m_fl = 0;
    bit        started = 0;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    function automatic bit model_hazard();
        bit reads_rd;
        reads_rd = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
        return m.v && m.il && m.rd != 0 && id_valid && reads_rd;
    endfunction

    function automatic bit [31:0] sat_inc(input bit [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 1;
    endfunction

    task automatic step();
        ex_t n;
        bit  hz;
        #1;
        hz = model_hazard();
        if (started) check("stall_if_id", stall_if_id, hz && !flush);
        n = m;
        if (rst) begin
            n = '0; m_bub = 0; m_fl = 0;
        end else if (!mem_stall) begin
            if (flush || hz) begin
                n = '0;
                if (flush) m_fl = sat_inc(m_fl);
                else       m_bub = sat_inc(m_bub);
            end else begin
                n.v = id_valid; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
                n.lr = id_load_regfile && id_valid; n.il = id_is_load && id_valid;
                n.ctrl = id_ctrl; n.pc = id_pc; n.imm = id_imm;
                n.d1 = id_rs1_data; n.d2 = id_rs2_data;
            end
        end
        @(posedge clk);
        #1;
        m = n;
        started = 1;
        check("exe_valid", exe_valid, m.v);
        check("exe_rs1", exe_rs1, m.rs1);
        check("exe_rs2", exe_rs2, m.rs2);
        check("exe_rd", exe_rd, m.rd);
        check("exe_load_regfile", exe_load_regfile, m.lr);
        check("exe_is_load", exe_is_load, m.il);
        check("exe_ctrl", exe_ctrl, m.ctrl);
        check("exe_pc", exe_pc, m.pc);
        check("exe_imm", exe_imm, m.imm);
        check("exe_rs1_data", exe_rs1_data, m.d1);
        check("exe_rs2_data", exe_rs2_data, m.d2);
        check("bubble_count", bubble_count, PERF ? m_bub : 32'd0);
        check("flush_count", flush_count, PERF ? m_fl : 32'd0);
    endtask

    task automatic set_id(input bit v, input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd,
                          input bit u1, input bit u2, input bit lr, input bit il);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_load_regfile = lr; id_is_load = il;
        id_ctrl = ctrl_word_t'($urandom); id_pc = $urandom; id_imm = $urandom;
        id_rs1_data = $urandom; id_rs2_data = $urandom;
    endtask

    task automatic set_id_rand();
        set_id(($urandom % 8) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom % 3) == 0);
    endtask

    initial begin
        rst = 1; mem_stall = 0; flush = 0;
        set_id_rand();
        step();
        check("rst_valid", exe_valid, 0);
        check("rst_ctrl", exe_ctrl, CTRL_NOP);
        check("rst_bubble_cnt", bubble_count, 0);
        check("rst_stall", stall_if_id, 0);
        rst = 0;

        // lw x5 then add x6,x5,x1: one bubble, then the add advances
        set_id(1, 0, 0, 5, 0, 0, 1, 1); step();
        set_id(1, 5, 1, 6, 1, 1, 1, 0); #1;
        check("s023_stall", stall_if_id, 1);
        step();
        check("s023_bubble", exe_valid, 0);
        step();
        check("s023_rs1", exe_rs1, 5);
        check("s023_valid", exe_valid, 1);

        // lw x0 followed by a reader of x0: no stall
        set_id(1, 0, 0, 0, 0, 0, 1, 1); step();
        set_id(1, 0, 0, 7, 1, 1, 1, 0); #1;
        check("s024_stall", stall_if_id, 0);
        step();
        check("s024_valid", exe_valid, 1);
        check("s024_bubble_cnt", bubble_count, PERF ? 32'd1 : 32'd0);

        // store reading rs2 only when id_uses_rs2 is set
        set_id(1, 0, 0, 5, 0, 0, 1, 1); step();
        set_id(1, 1, 5, 0, 1, 1, 0, 0); #1;
        check("s025_stall_rs2", stall_if_id, 1);
        step(); step();
        set_id(1, 0, 0, 5, 0, 0, 1, 1); step();
        set_id(1, 1, 5, 0, 1, 0, 0, 0); #1;
        check("s025_no_stall", stall_if_id, 0);
        step();

        // load-use together with flush: a single flush bubble
        set_id(1, 0, 0, 5, 0, 0, 1, 1); step();
        set_id(1, 5, 0, 6, 1, 0, 1, 0); flush = 1; #1;
        check("s026_stall", stall_if_id, 0);
        step();
        check("s026_bubble", exe_valid, 0);
        check("s026_flush_cnt", flush_count, PERF ? 32'd1 : 32'd0);
        check("s026_bubble_cnt", bubble_count, PERF ? 32'd2 : 32'd0);

        // freeze for three edges with flush pending, bubble once released
        flush = 0;
        set_id(1, 1, 2, 3, 1, 1, 1, 0); step();
        mem_stall = 1; flush = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 4, 4, 9, 1, 1, 1, 0);
            step();
            check("s027_hold_rd", exe_rd, 3);
            check("s027_hold_valid", exe_valid, 1);
        end
        mem_stall = 0; step();
        check("s027_bubble", exe_valid, 0);
        check("s027_flush_cnt", flush_count, PERF ? 32'd2 : 32'd0);

        // reset overrides a freeze and discards the held instruction
        flush = 0;
        set_id(1, 1, 2, 3, 1, 1, 1, 1); step();
        rst = 1; mem_stall = 1; step();
        check("s028_valid", exe_valid, 0);
        check("s028_ctrl", exe_ctrl, CTRL_NOP);
        check("s028_flush_cnt", flush_count, 0);
        check("s028_bubble_cnt", bubble_count, 0);
        rst = 0; mem_stall = 0;

        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom % 64) == 0;
            mem_stall = ($urandom % 5) == 0;
            flush     = ($urandom % 8) == 0;
            set_id_rand();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 The module SHALL have these ID-side inputs:
  - id_valid 1: decoded instruction valid
  - id_rs1, id_rs2, id_rd 5 each: register indices
  - id_uses_rs1, id_uses_rs2 1 each: source actually read
  - id_load_regfile 1: writes rd
  - id_is_load 1: memory load
  - id_ctrl ctrl_word_t: control word
  - id_pc, id_imm, id_rs1_data, id_rs2_data 32 each
REQ-003 The module SHALL have these control inputs:
  - mem_stall 1: global freeze (cache miss)
  - flush 1: taken branch/jump, kill younger instruction
REQ-004 The module SHALL drive registered EX-side outputs exe_valid, exe_rs1, exe_rs2, exe_rd, exe_load_regfile, exe_is_load, exe_ctrl, exe_pc, exe_imm, exe_rs1_data, exe_rs2_data, each matching the width of its id_ counterpart.
REQ-005 The module SHALL drive a combinational output stall_if_id 1, meaning hold the PC and the IF/ID register this cycle.
REQ-006 The module SHALL drive bubble_count 32 and flush_count 32 as outputs: performance counters (see Configuration).

Function
REQ-007 load_use SHALL equal: exe_valid & exe_is_load & exe_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==exe_rd) | (id_uses_rs2 & id_rs2==exe_rd)).
REQ-008 stall_if_id SHALL equal load_use & ~flush; it is combinational, with zero-cycle latency.
REQ-009 Register update priority at each clk edge SHALL be: rst > mem_stall > flush > load_use > normal.
REQ-010 With mem_stall=1 and rst=0, all exe_* registers SHALL hold their values; flush and load_use are ignored that cycle (callers hold flush until the stall clears).
REQ-011 Flush or load_use without mem_stall SHALL insert a bubble: exe_valid=0, exe_load_regfile=0, exe_is_load=0, exe_rd=0, exe_ctrl=CTRL_NOP; data fields are don't-care but SHALL be zeroed.
REQ-012 In a normal cycle, every exe_* register SHALL capture its id_* input; exe_load_regfile and exe_is_load SHALL be ANDed with id_valid.
REQ-013 A load-use stall SHALL last exactly one cycle; on the next edge the load has left EX, load_use deasserts, and the consumer advances (its operand comes from WB forwarding).
REQ-014 A load writing x0 SHALL never cause a stall.
REQ-015 Flush and load_use in the same cycle SHALL produce exactly one bubble, with stall_if_id=0.

Reset
REQ-016 While rst=1 at a clk edge, all exe_* outputs SHALL be 0 (exe_ctrl=CTRL_NOP); rst overrides mem_stall.
REQ-017 stall_if_id SHALL be 0 during and after reset until a qualifying load reaches EX.
REQ-018 Counters SHALL reset to 0; reset mid-stall SHALL discard the held instruction.

Configuration
REQ-019 With HAZARD_PERF_EN defined, bubble_count SHALL increment once per load_use bubble and flush_count once per flush bubble; both saturate at 32'hFFFF_FFFF and hold under mem_stall.
REQ-020 Without HAZARD_PERF_EN, the ports SHALL still exist, tied to 0, and no counter flops SHALL be generated.

Structure
REQ-021 ctrl_word_t, CTRL_NOP, rv32i_word and rv32i_reg SHALL live in the shared package rv32i_types.
REQ-022 load_use logic SHALL be a combinational sub-module named load_use_detect; the register file stays in id_ex_stage.

Verification
REQ-023 Scenario: EX holds lw x5 (valid) and ID holds add x6,x5,x1 -> stall_if_id=1; next edge exe_valid=0; following edge exe_rs1=5, exe_valid=1.
REQ-024 Scenario: EX holds lw x0 and ID reads x0 -> stall_if_id=0; no bubble; bubble_count unchanged.
REQ-025 Scenario: EX holds lw x5 and ID holds sw with id_uses_rs2=1, id_rs2=5 -> one-cycle stall; id_uses_rs2=0 with id_rs2=5 -> no stall.
REQ-026 Scenario: load_use and flush both 1 -> stall_if_id=0; one bubble; with the macro, flush_count+1 and bubble_count+0.
REQ-027 Scenario: mem_stall=1 for 3 cycles with flush=1 -> exe_* unchanged for 3 edges; bubble on the first edge after mem_stall drops.
REQ-028 Scenario: rst=1 asserted together with mem_stall=1 while exe_valid=1 -> next edge exe_valid=0, exe_ctrl=CTRL_NOP, counters 0.
